// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: fixed-latency mult/div with HI/LO ownership and mf/mt service.
// Results commit on the edge where the down-counter reaches zero; busy/start feed the hazard unit's stall logic.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic        md_busy,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic           sgn_q, sgn_d;

    logic [3:0]     op_eff;
    logic           is_mul, is_div;

    // A bubble must never start or write anything, so fold valid into the opcode.
    assign op_eff  = valid ? op : 4'b0000;
    assign is_mul  = (op_eff == OP_MULT) || (op_eff == OP_MULTU);
    assign is_div  = (op_eff == OP_DIV)  || (op_eff == OP_DIVU);

    assign start   = (state_q == IDLE) && (is_mul || is_div);
    assign busy    = (state_q != IDLE);
    assign md_busy = start | busy;
    assign hi      = hi_q;
    assign lo      = lo_q;

    always_comb begin
        mf_data = 32'h0;
        if (op_eff == OP_MFHI)
            mf_data = hi_q;
        else if (op_eff == OP_MFLO)
            mf_data = lo_q;
    end

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u, prod;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'h0, a_q} * {32'h0, b_q};
    assign prod   = sgn_q ? prod_s : prod_u;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    assign a_neg  = sgn_q & a_q[31];
    assign b_neg  = sgn_q & b_q[31];
    assign a_mag  = a_neg ? -a_q : a_q;
    assign b_mag  = b_neg ? -b_q : b_q;
    assign b_zero = (b_q == 32'h0);
    assign b_div  = b_zero ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_div;
    assign r_mag  = a_mag % b_div;
    assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem    = a_neg ? -r_mag : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = rs_val;
                    b_d     = rt_val;
                    sgn_d   = (op_eff == OP_MULT) || (op_eff == OP_DIV);
                    state_d = is_mul ? MUL : DIV;
                    cnt_d   = is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                end else if (op_eff == OP_MTHI) begin
                    hi_d = rs_val;
                end else if (op_eff == OP_MTLO) begin
                    lo_d = rs_val;
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DIV: begin
                if (cnt_q == '0) begin
                    // Divide by zero keeps HI/LO but still costs the full latency.
                    if (!b_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: arithmetic reference model with per-cycle compare plus literal spot checks.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        start, busy, md_busy;
    logic [31:0] mf_data, hi, lo;

    int total = 0;
    int bad   = 0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .start   (start),
        .busy    (busy),
        .md_busy (md_busy),
        .mf_data (mf_data),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Reference model: remaining-cycle count plus a pending result computed up front.
    int          rem_m;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_wr;
    longint      sa, sb, sq, sr, sp;
    logic [63:0] up;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_m = 0;
            m_hi  = 32'h0;
            m_lo  = 32'h0;
            p_wr  = 1'b0;
        end else if (rem_m > 0) begin
            rem_m = rem_m - 1;
            if (rem_m == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (valid) begin
            case (op)
                4'b0001: begin
                    sp    = longint'($signed(rs_val)) * longint'($signed(rt_val));
                    p_hi  = sp[63:32];
                    p_lo  = sp[31:0];
                    p_wr  = 1'b1;
                    rem_m = MC;
                end
                4'b0011: begin
                    up    = {32'h0, rs_val} * {32'h0, rt_val};
                    p_hi  = up[63:32];
                    p_lo  = up[31:0];
                    p_wr  = 1'b1;
                    rem_m = MC;
                end
                4'b0010: begin
                    p_wr = (rt_val != 32'h0);
                    if (p_wr) begin
                        sa   = longint'($signed(rs_val));
                        sb   = longint'($signed(rt_val));
                        sq   = sa / sb;
                        sr   = sa % sb;
                        p_lo = sq[31:0];
                        p_hi = sr[31:0];
                    end
                    rem_m = DC;
                end
                4'b0100: begin
                    p_wr = (rt_val != 32'h0);
                    if (p_wr) begin
                        p_lo = rs_val / rt_val;
                        p_hi = rs_val % rt_val;
                    end
                    rem_m = DC;
                end
                4'b0111: m_hi = rs_val;
                4'b1000: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    logic        e_busy, e_start;
    logic [31:0] e_mf;

    always @(negedge clk) begin
        e_busy  = (rem_m > 0);
        e_start = valid && (op inside {4'd1, 4'd2, 4'd3, 4'd4}) && (rem_m == 0);
        e_mf    = !valid ? 32'h0 : (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'h0;
        check1("cyc_busy", busy, e_busy);
        check1("cyc_start", start, e_start);
        check1("cyc_md_busy", md_busy, e_start | e_busy);
        check("cyc_mf_data", mf_data, e_mf);
        check("cyc_hi", hi, m_hi);
        check("cyc_lo", lo, m_lo);
        if (busy && valid && (op inside {[4'd1:4'd8]})) begin
            total++;
            bad++;
            $display("FAIL illegal_op_while_busy: op=%h", op);
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        valid  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        check1("issue_start", start, 1'b1);
        check1("issue_md_busy", md_busy, 1'b1);
        @(posedge clk);
        #1;
        valid  = 1'b0;
        op     = 4'h0;
        rs_val = 32'h0;
        rt_val = 32'h0;
    endtask

    task automatic wait_idle(input int n_exp, input string name);
        int n = 0;
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                check1({name, "_start_low"}, start, 1'b0);
            end else begin
                done = 1'b1;
            end
        end
        check({name, "_busy_cycles"}, n, n_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b0;
        valid  = 1'b0;
        op     = 4'h0;
        rs_val = 32'h0;
        rt_val = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue(4'b0001, 32'hFFFFFFFD, 32'd5);
        wait_idle(MC, "mult");
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);
        check("model_mult_hi", m_hi, 32'hFFFFFFFF);
        check("model_mult_lo", m_lo, 32'hFFFFFFF1);

        issue(4'b0011, 32'hFFFFFFFF, 32'd2);
        wait_idle(MC, "multu");
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        issue(4'b0010, 32'hFFFFFFF9, 32'd2);
        wait_idle(DC, "div");
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("model_div_lo", m_lo, 32'hFFFFFFFD);
        check("model_div_hi", m_hi, 32'hFFFFFFFF);

        issue(4'b0100, 32'hFFFFFFF9, 32'd2);
        wait_idle(DC, "divu");
        check("divu_lo", lo, 32'h7FFFFFFC);
        check("divu_hi", hi, 32'h00000001);

        // Bubbles and unknown opcodes must do nothing.
        valid = 1'b0; op = 4'b0001; rs_val = 32'h1; rt_val = 32'h1;
        @(negedge clk);
        check1("bubble_start", start, 1'b0);
        check1("bubble_md_busy", md_busy, 1'b0);
        @(posedge clk); #1;
        valid = 1'b1; op = 4'hF;
        @(negedge clk);
        check1("badop_start", start, 1'b0);
        @(posedge clk); #1;
        check1("badop_busy", busy, 1'b0);
        check("badop_hi", hi, 32'h00000001);
        valid = 1'b0; op = 4'h0; rs_val = 32'h0; rt_val = 32'h0;

        valid = 1'b1; op = 4'b0111; rs_val = 32'h12345678;
        @(posedge clk); #1;
        valid = 1'b0; op = 4'h0; rs_val = 32'h0;
        check("mthi_hi", hi, 32'h12345678);

        issue(4'b0100, 32'd55, 32'd0);
        wait_idle(DC, "divu0");
        check("divu0_hi", hi, 32'h12345678);
        check("divu0_lo", lo, 32'h7FFFFFFC);

        valid = 1'b1; op = 4'b0101;
        @(negedge clk);
        check("mfhi_data", mf_data, 32'h12345678);
        @(posedge clk); #1;
        op = 4'b0110;
        @(negedge clk);
        check("mflo_data", mf_data, 32'h7FFFFFFC);
        @(posedge clk); #1;
        op = 4'b1000; rs_val = 32'hCAFEF00D;
        @(posedge clk); #1;
        valid = 1'b0; op = 4'h0; rs_val = 32'h0;
        check("mtlo_lo", lo, 32'hCAFEF00D);

        // Overflow divide followed by a mult issued in the first idle cycle.
        issue(4'b0010, 32'h80000000, 32'hFFFFFFFF);
        for (int i = 0; i < DC; i++) begin
            @(negedge clk);
            check1("b2b_md_busy", md_busy, 1'b1);
        end
        @(posedge clk); #1;
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'h00000000);
        issue(4'b0001, 32'h00010000, 32'h00010000);
        wait_idle(MC, "b2b_mult");
        check("b2b_hi", hi, 32'h00000001);
        check("b2b_lo", lo, 32'h00000000);

        issue(4'b0010, 32'd100, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check1("arst_busy", busy, 1'b0);
        check1("arst_md_busy", md_busy, 1'b0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check1("post_rst_busy", busy, 1'b0);
        check("post_rst_hi", hi, 32'h0);
        check("post_rst_lo", lo, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
